int_to_float: RTL and testbench



---
 rtl/int_to_float_pkg.sv | 29 ++
 rtl/int_to_float_lead_one_det.sv | 19 +
 rtl/int_to_float.sv | 116 +++++++++++
 tb/tb_int_to_float.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/int_to_float_pkg.sv
// Float format shared by the float blocks, as {sign, exp, frac}.
// E_bit/F_bit default to 8/23; E_BIAS and FLOAT_W are derived from them.
`ifndef E_bit
`define E_bit 8
`endif
`ifndef F_bit
`define F_bit 23
`endif
`ifndef E_BIAS
`define E_BIAS ((1 << (`E_bit - 1)) - 1)
`endif
`ifndef FLOAT_W
`define FLOAT_W (1 + `E_bit + `F_bit)
`endif

package int_to_float_pkg;

  localparam int unsigned E_W     = `E_bit;
  localparam int unsigned F_W     = `F_bit;
  localparam int unsigned FLOAT_W = `FLOAT_W;
  localparam int unsigned E_BIAS  = `E_BIAS;

  typedef struct packed {
    logic           sign;
    logic [E_W-1:0] exp;
    logic [F_W-1:0] frac;
  } float_t;

endpackage

// File: rtl/int_to_float_lead_one_det.sv
// Leading-one detector: position of the highest set bit, plus an all-zero flag.
module lead_one_det #(
  parameter int INT_W = 32,
  localparam int PW = (INT_W > 1) ? $clog2(INT_W) : 1
) (
  input  logic [INT_W-1:0] vec,
  output logic [PW-1:0]    pos,
  output logic             zero
);

  always_comb begin
    pos  = '0;
    zero = ~|vec;
    for (int unsigned i = 0; i < INT_W; i++) begin
      if (vec[i]) pos = PW'(i);
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Three-stage signed integer to float converter with valid/ready and global stall.
// Rounding: round-to-nearest-even when INT2FLOAT_RNE_EN is defined, truncate otherwise.
module int_to_float
  import int_to_float_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INT_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLOAT_W-1:0] out_data
);

  localparam int unsigned BIAS  = E_BIAS;
  localparam int          PW    = (INT_W > 1) ? $clog2(INT_W) : 1;
  localparam int          EXW   = E_W + 1;
  localparam int          W_EXT = INT_W + F_W + 1;
  localparam logic [EXW-1:0] EXP_MAX = EXW'((1 << E_W) - 1);

  logic             adv;
  logic             out_valid_q;
  float_t           out_q;

  logic             s0_valid, s0_sign;
  logic [INT_W-1:0] s0_mag, in_mag;

  logic [PW-1:0]    lod_pos;
  logic             lod_zero;

  logic             s1_valid, s1_sign, s1_zero;
  logic [INT_W-1:0] s1_mant;
  logic [EXW-1:0]   s1_exp;

  logic [W_EXT-1:0] ext;
  logic [F_W-1:0]   frac_t, frac_r;
  logic [EXW-1:0]   exp_r;
  float_t           s2_data;
`ifdef INT2FLOAT_RNE_EN
  logic             guard, sticky, round_up;
  logic [F_W:0]     frac_sum;
`endif

  // Gating with rst keeps any handshake from completing while reset is held.
  assign out_valid = out_valid_q & ~rst;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_data  = out_q;

  // Most negative input negates to 2^(INT_W-1), which still fits unsigned.
  assign in_mag = in_data[INT_W-1] ? (~in_data + INT_W'(1)) : in_data;

  lead_one_det #(.INT_W(INT_W)) u_lod (
    .vec  (s0_mag),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  // Trailing zeros guarantee a guard bit exists even when INT_W-1 < F_W.
  always_comb begin
    ext    = {s1_mant, {(F_W + 1){1'b0}}};
    frac_t = F_W'(ext >> (W_EXT - 1 - F_W));
`ifdef INT2FLOAT_RNE_EN
    guard    = ext[W_EXT-2-F_W];
    sticky   = (ext << (F_W + 2)) != '0;
    round_up = guard & (sticky | frac_t[0]);
    frac_sum = {1'b0, frac_t} + (F_W + 1)'(round_up);
    frac_r   = frac_sum[F_W] ? '0 : frac_sum[F_W-1:0];
    exp_r    = s1_exp + EXW'(frac_sum[F_W]);
`else
    frac_r = frac_t;
    exp_r  = s1_exp;
`endif
    s2_data = '0;
    if (!s1_zero) begin
      s2_data.sign = s1_sign;
      if (exp_r >= EXP_MAX) begin
        s2_data.exp  = '1;
        s2_data.frac = '0;
      end else begin
        s2_data.exp  = exp_r[E_W-1:0];
        s2_data.frac = frac_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid    <= 1'b0;
      s0_sign     <= 1'b0;
      s0_mag      <= '0;
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_zero     <= 1'b0;
      s1_mant     <= '0;
      s1_exp      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (adv) begin
      s0_valid    <= in_valid;
      s0_sign     <= in_data[INT_W-1];
      s0_mag      <= in_mag;
      s1_valid    <= s0_valid;
      s1_sign     <= s0_sign;
      s1_zero     <= lod_zero;
      s1_mant     <= s0_mag << (PW'(INT_W - 1) - lod_pos);
      s1_exp      <= EXW'(BIAS) + EXW'(lod_pos);
      out_valid_q <= s1_valid;
      out_q       <= s2_data;
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Bench for int_to_float (8/23, INT_W=32): vector table, backpressure, reset, random stream.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  int_to_float #(.INT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Reference: float value from integer arithmetic on the magnitude.
  function automatic logic [31:0] ref_float(input logic [31:0] v);
    logic s;
    longint unsigned mag, q;
    int e, sh;
    s   = v[31];
    mag = s ? (64'h1_0000_0000 - {32'b0, v}) : {32'b0, v};
    if (mag == 0) return '0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      sh = e - 23;
      q  = mag >> sh;
`ifdef INT2FLOAT_RNE_EN
      begin
        longint unsigned rem, half;
        rem  = mag - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
          q = q >> 1;
          e++;
        end
      end
`endif
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (in_valid && in_ready) expq.push_back(ref_float(in_data));
      if (out_valid && out_ready) begin
        delivered++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h expected=none", out_data);
        end else begin
          check("stream_data", out_data, expq.pop_front());
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] din;
    logic [31:0] exp_t;
    logic [31:0] exp_r;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n, start_del, idx, stall_left;
    bit stalled, acc;
    logic [31:0] want;

    tbl[0] = '{"one",      32'd1,          32'h3F800000, 32'h3F800000};
    tbl[1] = '{"minus1",   32'hFFFFFFFF,   32'hBF800000, 32'hBF800000};
    tbl[2] = '{"zero",     32'd0,          32'h00000000, 32'h00000000};
    tbl[3] = '{"most_neg", 32'h80000000,   32'hCF000000, 32'hCF000000};
    tbl[4] = '{"most_pos", 32'h7FFFFFFF,   32'h4EFFFFFF, 32'h4F000000};
    tbl[5] = '{"tie_even", 32'd16777217,   32'h4B800000, 32'h4B800000};
    tbl[6] = '{"tie_odd",  32'd16777219,   32'h4B800001, 32'h4B800002};
    tbl[7] = '{"three",    32'd3,          32'h40400000, 32'h40400000};
    tbl[8] = '{"minus5",   32'hFFFFFFFB,   32'hC0A00000, 32'hC0A00000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);

    foreach (tbl[i]) begin
`ifdef INT2FLOAT_RNE_EN
      want = tbl[i].exp_r;
`else
      want = tbl[i].exp_t;
`endif
      in_data = tbl[i].din;
      in_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        n++;
        if (out_valid) break;
      end
      check({tbl[i].name, "_latency"}, n, 32'd3);
      check(tbl[i].name, out_data, want);
      @(posedge clk); #1;
    end

    // Backpressure: 1..5 back-to-back, hold the first result for 5 cycles.
    start_del = delivered; idx = 0; stalled = 0; stall_left = 0;
    in_data = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40 && (delivered - start_del) < 5; c++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_hold", out_data, 32'h3F800000);
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_in_ready", {31'b0, in_ready}, {31'b0, out_ready});
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 5) in_data = idx + 1;
        else in_valid = 1'b0;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (!stalled && out_valid) begin
        stalled = 1;
        out_ready = 1'b0;
        stall_left = 5;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", delivered - start_del, 32'd5);
    check("bp_queue_empty", expq.size(), 32'd0);

    // Reset with two values in flight: nothing may emerge afterwards.
    in_valid = 1'b1; in_data = 32'd7;
    @(posedge clk); #1 in_data = 32'd8;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    #3 check("rst_out_valid_during", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    expq.delete();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      check("rst_no_stale", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Random stream with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: in_data = $urandom_range(0, 16) - 8;
        1: in_data = 32'h80000000;
        2: in_data = 32'h7FFFFFFF;
        3: in_data = (32'd1 << $urandom_range(0, 30)) + $urandom_range(0, 3);
        default: in_data = $urandom;
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && expq.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_empty", expq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
